eq_clock: RTL and testbench
===========================

EQ_CLOCK -- requirements
Module: eq_clock

Interface
REQ-001 Parameter QTR, default 4: MHZ48 ticks per quadrature quarter; legal range 2..16.
REQ-002 Parameter WSW, default 2: width of the programmed wait-state input WS.
REQ-003 Parameter STRETCH_MAX, default 15: maximum number of extra (stretched) quarters per bus cycle; legal range 1..255.
REQ-004 Parameter STB, default 2: nSTROBE low width in ticks; legal range 1..QTR.
REQ-005 Parameter NDIV, default 2: number of divided-clock outputs.
REQ-006 One clock and a synchronous, active-high reset: MHZ48  in  1  master clock; all state changes occur on its rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 nWAIT  in  1  asynchronous active-low stretch request.
REQ-009 WS  in  WSW  programmed wait-state quarters inserted every bus cycle.
REQ-010 DIVOUT  out  NDIV  free-running binary divider; DIVOUT[0] is MHZ48/2 (24 MHz), DIVOUT[1] is MHZ48/4 (12 MHz).
REQ-011 nQ  out  1  active-low 6809 Q clock.
REQ-012 nE  out  1  active-low 6809 E clock.
REQ-013 nSTROBE  out  1  active-low strobe at the falling edge of E.
REQ-014 STRETCH  out  1  high during every stretched quarter.
REQ-015 TIMEOUT  out  1  sticky flag: a stretch was forcibly ended.

Function
REQ-016 All outputs SHALL be registered; no combinational input-to-output path.
REQ-017 Quarter tick counter t SHALL count 0..QTR-1, then wrap to 0 and advance the phase.
REQ-018 Phases SHALL cycle PH0 (Q=1,E=0), PH1 (Q=1,E=1), PH2 (Q=0,E=1), PH3 (Q=0,E=0); nQ=~Q and nE=~E.
REQ-019 nWAIT SHALL pass through a two-flop synchronizer; the stretch decision uses the synchronized value only (2-tick latency).
REQ-020 On entry to PH0 (t=0), WS SHALL be loaded into the wait-state counter ws_cnt, and stretch_cnt SHALL be cleared.
REQ-021 At the end of PH2 (t=QTR-1), stretch_cnt==STRETCH_MAX SHALL force the transition to PH3; TIMEOUT SHALL be set if ws_cnt!=0 or synchronized nWAIT==0.
REQ-022 Else, ws_cnt!=0 SHALL extend PH2 by one quarter, decrement ws_cnt and increment stretch_cnt.
REQ-023 Else, synchronized nWAIT==0 SHALL extend PH2 by one quarter and increment stretch_cnt.
REQ-024 Else, the phase SHALL advance to PH3.
REQ-025 WS stretching SHALL take precedence over nWAIT; nWAIT stretching begins only after ws_cnt reaches 0.
REQ-026 STRETCH SHALL be 1 for all ticks of each extended PH2 quarter and 0 otherwise.
REQ-027 nSTROBE SHALL be 0 for ticks t=0..STB-1 of PH3 and 1 otherwise.
REQ-028 DIVOUT SHALL increment every tick, regardless of phase or stretch state.
REQ-029 Unstretched bus cycle SHALL be 4*QTR ticks; a stretched cycle SHALL be (4+stretch_cnt)*QTR ticks.

Reset
REQ-030 While RESET=1: phase=PH3, t=QTR-1, ws_cnt=0, stretch_cnt=0, synchronizer flops=1, DIVOUT=0, nQ=1, nE=1, nSTROBE=1, STRETCH=0, TIMEOUT=0.
REQ-031 The first rising edge with RESET=0 SHALL enter PH0 at t=0, and nQ SHALL go 0 on that edge.
REQ-032 RESET asserted mid-stretch SHALL abort the cycle immediately; no strobe pulse SHALL be emitted.
REQ-033 TIMEOUT SHALL be cleared only by RESET.

Structure
REQ-034 Package eq_clock_pkg SHALL hold the phase enumeration PH0..PH3 and the parameter defaults.
REQ-035 The nWAIT synchronizer SHALL be a sub-module named sync2.

Verification
REQ-036 Defaults, WS=0, nWAIT=1: the bus cycle is 16 ticks (333.3 ns); nQ falls at tick 0; nE falls at tick 4; nQ rises at tick 8; nE rises at tick 12; nSTROBE is low for ticks 12-13.
REQ-037 WS=2, nWAIT=1: PH2 lasts 12 ticks; STRETCH is high for 8 ticks; the cycle is 24 ticks.
REQ-038 nWAIT low from 880 ns to 1880 ns after reset release: PH2 is extended in whole quarters until the synchronized nWAIT is high at a quarter end; nE never glitches.
REQ-039 nWAIT held low: PH2 lasts 64 ticks; TIMEOUT=1 from the following PH3 onward; subsequent cycles with nWAIT=1 are 16 ticks.
REQ-040 RESET pulsed during a stretch: all outputs take their reset values on the next edge; DIVOUT restarts at 0 and counts 1, 2, 3.

Source files
------------

// File: rtl/eq_clock_pkg.sv
// Shared types and default parameter values for the 6809 quadrature clock generator.
package eq_clock_pkg;

    typedef enum logic [1:0] {
        PH0 = 2'd0,   // Q=1, E=0
        PH1 = 2'd1,   // Q=1, E=1
        PH2 = 2'd2,   // Q=0, E=1
        PH3 = 2'd3    // Q=0, E=0
    } phase_t;

    localparam int QTR_DEF         = 4;
    localparam int WSW_DEF         = 2;
    localparam int STRETCH_MAX_DEF = 15;
    localparam int STB_DEF         = 2;
    localparam int NDIV_DEF        = 2;

    // Active-high Q level for a given phase.
    function automatic logic q_of(input phase_t ph);
        return (ph == PH0) || (ph == PH1);
    endfunction

    // Active-high E level for a given phase.
    function automatic logic e_of(input phase_t ph);
        return (ph == PH1) || (ph == PH2);
    endfunction

endpackage

// File: rtl/eq_clock_if.sv
// Bus bundle between the clock generator (master) and the bus logic that consumes it (slave).
interface eq_clock_if
    import eq_clock_pkg::*;
#(
    parameter int WSW  = WSW_DEF,
    parameter int NDIV = NDIV_DEF
);

    logic            nWAIT;
    logic [WSW-1:0]  WS;
    logic [NDIV-1:0] DIVOUT;
    logic            nQ;
    logic            nE;
    logic            nSTROBE;
    logic            STRETCH;
    logic            TIMEOUT;

    modport master (
        input  nWAIT, WS,
        output DIVOUT, nQ, nE, nSTROBE, STRETCH, TIMEOUT
    );

    modport slave (
        output nWAIT, WS,
        input  DIVOUT, nQ, nE, nSTROBE, STRETCH, TIMEOUT
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Shift the asynchronous level through two flops; reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/eq_clock.sv
// 6809 Q/E quadrature clock generator with wait-state and nWAIT stretching of PH2,
// a strobe at the falling edge of E, and a free-running binary divider.
module eq_clock
    import eq_clock_pkg::*;
#(
    parameter int QTR         = QTR_DEF,
    parameter int WSW         = WSW_DEF,
    parameter int STRETCH_MAX = STRETCH_MAX_DEF,
    parameter int STB         = STB_DEF,
    parameter int NDIV        = NDIV_DEF
) (
    input  logic        MHZ48,
    input  logic        RESET,
    eq_clock_if.master  bus
);

    // One extra bit so that STB==QTR is representable in the strobe compare.
    localparam int TW  = $clog2(QTR + 1);
    localparam int SCW = $clog2(STRETCH_MAX + 1);

    localparam logic [TW-1:0]  T_LAST = TW'(QTR - 1);
    localparam logic [TW-1:0]  STB_T  = TW'(STB);
    localparam logic [SCW-1:0] SC_MAX = SCW'(STRETCH_MAX);

    phase_t           phase, phase_nxt;
    logic [TW-1:0]    t, t_nxt;
    logic [WSW-1:0]   ws_cnt, ws_cnt_nxt;
    logic [SCW-1:0]   stretch_cnt, stretch_cnt_nxt;
    logic             ext, ext_nxt;
    logic             timeout, timeout_nxt;
    logic             nq_r, ne_r, nstb_r;
    logic             nq_nxt, ne_nxt, nstb_nxt;
    logic [NDIV-1:0]  div_cnt;
    logic             nwait_s;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync2 (
        .clk (MHZ48),
        .rst (RESET),
        .d   (bus.nWAIT),
        .q   (nwait_s)
    );

    // Next-state: tick counter, phase sequencing and PH2 stretch decision at each quarter end.
    always_comb begin
        phase_nxt       = phase;
        t_nxt           = t + TW'(1);
        ws_cnt_nxt      = ws_cnt;
        stretch_cnt_nxt = stretch_cnt;
        ext_nxt         = ext;
        timeout_nxt     = timeout;

        if (t == T_LAST) begin
            t_nxt   = '0;
            ext_nxt = 1'b0;
            unique case (phase)
                PH0: phase_nxt = PH1;
                PH1: phase_nxt = PH2;
                PH2: begin
                    if (stretch_cnt == SC_MAX) begin
                        // Stretch budget exhausted: end the cycle regardless of pending requests.
                        phase_nxt = PH3;
                        if ((ws_cnt != '0) || !nwait_s) begin
                            timeout_nxt = 1'b1;
                        end
                    end else if (ws_cnt != '0) begin
                        ws_cnt_nxt      = ws_cnt - WSW'(1);
                        stretch_cnt_nxt = stretch_cnt + SCW'(1);
                        ext_nxt         = 1'b1;
                    end else if (!nwait_s) begin
                        stretch_cnt_nxt = stretch_cnt + SCW'(1);
                        ext_nxt         = 1'b1;
                    end else begin
                        phase_nxt = PH3;
                    end
                end
                PH3: begin
                    phase_nxt       = PH0;
                    ws_cnt_nxt      = bus.WS;
                    stretch_cnt_nxt = '0;
                end
                default: phase_nxt = PH3;
            endcase
        end

        // Output levels are taken from the next state so they change on the same edge.
        nq_nxt   = ~q_of(phase_nxt);
        ne_nxt   = ~e_of(phase_nxt);
        nstb_nxt = ~((phase_nxt == PH3) && (t_nxt < STB_T));
    end

    // State and registered outputs.
    always_ff @(posedge MHZ48) begin
        if (RESET) begin
            phase       <= PH3;
            t           <= T_LAST;
            ws_cnt      <= '0;
            stretch_cnt <= '0;
            ext         <= 1'b0;
            timeout     <= 1'b0;
            nq_r        <= 1'b1;
            ne_r        <= 1'b1;
            nstb_r      <= 1'b1;
        end else begin
            phase       <= phase_nxt;
            t           <= t_nxt;
            ws_cnt      <= ws_cnt_nxt;
            stretch_cnt <= stretch_cnt_nxt;
            ext         <= ext_nxt;
            timeout     <= timeout_nxt;
            nq_r        <= nq_nxt;
            ne_r        <= ne_nxt;
            nstb_r      <= nstb_nxt;
        end
    end

    // Free-running binary divider, independent of phase and stretch.
    always_ff @(posedge MHZ48) begin
        if (RESET) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + NDIV'(1);
        end
    end

    assign bus.DIVOUT  = div_cnt;
    assign bus.nQ      = nq_r;
    assign bus.nE      = ne_r;
    assign bus.nSTROBE = nstb_r;
    assign bus.STRETCH = ext;
    assign bus.TIMEOUT = timeout;

endmodule

// File: tb/tb_eq_clock.sv
// Directed bench for eq_clock: reset state, default waveform, table of bus-cycle shapes,
// reset during a stretch, and an nWAIT window measured from reset release.
module tb_eq_clock;

    import eq_clock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    eq_clock_if bus_if ();

    eq_clock dut (
        .MHZ48 (clk),
        .RESET (rst),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   ws;
        logic nw;
        int   cyc;
        int   ph2;
        int   str;
        int   stb;
        int   to;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Program inputs, wait for the next PH0 entry, then measure that one bus cycle.
    task automatic measure(input int ws, input logic nw, output int cyc, output int ph2,
                           output int str, output int stb, output int to_ph3, output int found);
        logic prev;
        logic fall;
        int   guard;
        bus_if.WS    = ws[1:0];
        bus_if.nWAIT = nw;
        prev  = bus_if.nQ;
        fall  = 1'b0;
        guard = 0;
        while (!fall && guard < 200) begin
            @(negedge clk);
            guard++;
            fall = prev && !bus_if.nQ;
            prev = bus_if.nQ;
        end
        found  = fall ? 1 : 0;
        cyc    = 0;
        ph2    = 0;
        str    = 0;
        stb    = 0;
        to_ph3 = -1;
        fall   = 1'b0;
        while (!fall && cyc < 400) begin
            if (bus_if.nQ && !bus_if.nE) ph2++;
            if (bus_if.STRETCH) str++;
            if (!bus_if.nSTROBE) stb++;
            if (bus_if.nQ && bus_if.nE && to_ph3 < 0) to_ph3 = int'(bus_if.TIMEOUT);
            cyc++;
            @(negedge clk);
            fall = prev && !bus_if.nQ;
            prev = bus_if.nQ;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ph2, str, stb, to_ph3, found;
        int guard, nstr, first_str, glitch;

        //            ws nw    cyc ph2 str stb to
        vecs[0] = '{0, 1'b1, 16,  4,  0, 2, 0};
        vecs[1] = '{1, 1'b1, 20,  8,  4, 2, 0};
        vecs[2] = '{2, 1'b1, 24, 12,  8, 2, 0};
        vecs[3] = '{3, 1'b1, 28, 16, 12, 2, 0};
        vecs[4] = '{0, 1'b0, 76, 64, 60, 2, 1};
        vecs[5] = '{0, 1'b1, 16,  4,  0, 2, 1};

        bus_if.nWAIT = 1'b1;
        bus_if.WS    = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nq",      int'(bus_if.nQ),      1);
        chk("rst_ne",      int'(bus_if.nE),      1);
        chk("rst_nstrobe", int'(bus_if.nSTROBE), 1);
        chk("rst_stretch", int'(bus_if.STRETCH), 0);
        chk("rst_timeout", int'(bus_if.TIMEOUT), 0);
        chk("rst_divout",  int'(bus_if.DIVOUT),  0);

        // Default cycle waveform, tick 0 is the first edge after reset release.
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("dflt_nq_t%0d", k),  int'(bus_if.nQ),      (k < 8) ? 0 : 1);
            chk($sformatf("dflt_ne_t%0d", k),  int'(bus_if.nE),      (k >= 4 && k < 12) ? 0 : 1);
            chk($sformatf("dflt_stb_t%0d", k), int'(bus_if.nSTROBE), (k == 12 || k == 13) ? 0 : 1);
            chk($sformatf("dflt_div_t%0d", k), int'(bus_if.DIVOUT),  (k + 1) % 4);
        end

        for (int i = 0; i < 6; i++) begin
            measure(vecs[i].ws, vecs[i].nw, cyc, ph2, str, stb, to_ph3, found);
            chk($sformatf("row%0d_start", i),   found,  1);
            chk($sformatf("row%0d_cycle", i),   cyc,    vecs[i].cyc);
            chk($sformatf("row%0d_ph2", i),     ph2,    vecs[i].ph2);
            chk($sformatf("row%0d_stretch", i), str,    vecs[i].str);
            chk($sformatf("row%0d_strobe", i),  stb,    vecs[i].stb);
            chk($sformatf("row%0d_timeout", i), to_ph3, vecs[i].to);
        end

        // Reset asserted in the middle of a wait-state stretch.
        bus_if.WS    = 2'd3;
        bus_if.nWAIT = 1'b1;
        guard = 0;
        while (!bus_if.STRETCH && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_found_stretch", int'(bus_if.STRETCH), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_nq",      int'(bus_if.nQ),      1);
        chk("midrst_ne",      int'(bus_if.nE),      1);
        chk("midrst_nstrobe", int'(bus_if.nSTROBE), 1);
        chk("midrst_stretch", int'(bus_if.STRETCH), 0);
        chk("midrst_timeout", int'(bus_if.TIMEOUT), 0);
        chk("midrst_divout",  int'(bus_if.DIVOUT),  0);
        @(negedge clk);
        chk("midrst_nstrobe_hold", int'(bus_if.nSTROBE), 1);
        bus_if.WS = '0;
        rst       = 1'b0;

        // nWAIT low from tick 42 to tick 90 after this release.
        nstr      = 0;
        first_str = -1;
        glitch    = 0;
        for (int k = 0; k <= 104; k++) begin
            @(negedge clk);
            if (k < 3) chk($sformatf("rel_div_t%0d", k), int'(bus_if.DIVOUT), k + 1);
            if (k == 0) chk("rel_nq_t0", int'(bus_if.nQ), 0);
            if (bus_if.STRETCH) begin
                nstr++;
                if (first_str < 0) first_str = k;
            end
            if (k >= 52 && k <= 95 && bus_if.nE) glitch++;
            if (k == 96) begin
                chk("win_ne_rise_t96",  int'(bus_if.nE),      1);
                chk("win_strobe_t96",   int'(bus_if.nSTROBE), 0);
            end
            if (k == 99)  chk("win_nq_t99",  int'(bus_if.nQ), 1);
            if (k == 100) chk("win_nq_t100", int'(bus_if.nQ), 0);
            if (k == 42) bus_if.nWAIT = 1'b0;
            if (k == 90) bus_if.nWAIT = 1'b1;
        end
        chk("win_stretch_ticks", nstr,      36);
        chk("win_first_stretch", first_str, 60);
        chk("win_ne_glitches",   glitch,    0);
        chk("win_timeout",       int'(bus_if.TIMEOUT), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
